// File: rtl/arbiter_2req.sv
// ---------------------------------------------------------------------------
// arbiter_2req
//   Two-requester mutual-exclusion arbiter for one shared resource.
//   Requests are sampled on every rising clock edge. Grants are registered
//   and are always one-hot or zero. The current owner keeps the grant for as
//   long as its request stays high. The grant then drops to IDLE for at least
//   one cycle before the other requester can be served.
//
//   Configuration macro: ARBITER_ROUND_ROBIN_EN
//     undefined : fixed priority, req_0 wins contention in IDLE.
//     defined   : a last_owner register (reset value 1) records the most
//                 recent grant, and contention in IDLE goes to the other
//                 requester.
//
// Ports
//   clock  in   rising-edge clock, single clock domain
//   reset  in   asynchronous active-high reset
//   req_0  in   level request from requester 0
//   req_1  in   level request from requester 1
//   gnt_0  out  registered grant to requester 0
//   gnt_1  out  registered grant to requester 1
// ---------------------------------------------------------------------------
module arbiter_2req (
    input  logic clock,
    input  logic reset,
    input  logic req_0,
    input  logic req_1,
    output logic gnt_0,
    output logic gnt_1
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   gnt_0_q;
    logic   gnt_1_q;

`ifdef ARBITER_ROUND_ROBIN_EN
    // 0: requester 0 was granted most recently, 1: requester 1 was.
    logic   last_owner_q;
    logic   last_owner_d;
`endif

    // Next-state decode for the grant FSM.
    always_comb begin
        state_d = IDLE;
`ifdef ARBITER_ROUND_ROBIN_EN
        last_owner_d = last_owner_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_0 && req_1) begin
`ifdef ARBITER_ROUND_ROBIN_EN
                    // Serve the requester that did not own the resource last.
                    if (last_owner_q) begin
                        state_d = GNT0;
                    end else begin
                        state_d = GNT1;
                    end
`else
                    state_d = GNT0;
`endif
                end else if (req_0) begin
                    state_d = GNT0;
                end else if (req_1) begin
                    state_d = GNT1;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT0: begin
                // The owner holds the grant; the other request is ignored.
                if (req_0) begin
                    state_d = GNT0;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT1: begin
                if (req_1) begin
                    state_d = GNT1;
                end else begin
                    state_d = IDLE;
                end
            end
            // The unused encoding 2'b11 recovers to IDLE.
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef ARBITER_ROUND_ROBIN_EN
        if (state_d == GNT0) begin
            last_owner_d = 1'b0;
        end else if (state_d == GNT1) begin
            last_owner_d = 1'b1;
        end else begin
            last_owner_d = last_owner_q;
        end
`endif
    end

    // State register. Grants are registered from the next state, so they
    // change in the same cycle as the state they reflect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            gnt_0_q      <= 1'b0;
            gnt_1_q      <= 1'b0;
`ifdef ARBITER_ROUND_ROBIN_EN
            last_owner_q <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            gnt_0_q      <= (state_d == GNT0);
            gnt_1_q      <= (state_d == GNT1);
`ifdef ARBITER_ROUND_ROBIN_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    assign gnt_0 = gnt_0_q;
    assign gnt_1 = gnt_1_q;

endmodule

// File: tb/tb_arbiter_2req.sv
// ---------------------------------------------------------------------------
// tb_arbiter_2req
//   Directed and random self-checking bench for arbiter_2req. Inputs are
//   driven 1 time unit after a rising edge. Outputs are sampled at that same
//   point, after the edge that registered them.
// ---------------------------------------------------------------------------
module tb_arbiter_2req;

    logic clock;
    logic reset;
    logic req_0;
    logic req_1;
    logic gnt_0;
    logic gnt_1;

    int tests_run;
    int tests_failed;

    arbiter_2req dut (
        .clock (clock),
        .reset (reset),
        .req_0 (req_0),
        .req_1 (req_1),
        .gnt_0 (gnt_0),
        .gnt_1 (gnt_1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Pulse reset with both requests low, then release it mid-cycle.
    task automatic do_reset();
        req_0 = 1'b0;
        req_1 = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        // Reset is held from time 0.
        step();
        step();
        tests_run++;
        if ({gnt_0, gnt_1} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_state: got %b want 00", {gnt_0, gnt_1});
        end
        reset = 1'b0;
        req_0 = 1'b1;
        step();
        tests_run++;
        if ({gnt_0, gnt_1} !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_pre_grant: got %b want 10", {gnt_0, gnt_1});
        end
        // Assert reset mid-cycle while the grant is held.
        #3;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({gnt_0, gnt_1} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_async_drop: got %b want 00", {gnt_0, gnt_1});
        end
        step();
        tests_run++;
        if ({gnt_0, gnt_1} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_held: got %b want 00", {gnt_0, gnt_1});
        end
        req_0 = 1'b0;
        reset = 1'b0;
        step();
        tests_run++;
        if ({gnt_0, gnt_1} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_release_idle: got %b want 00", {gnt_0, gnt_1});
        end
    endtask

    task automatic test_single();
        req_0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            tests_run++;
            if ({gnt_0, gnt_1} !== 2'b10) begin
                tests_failed++;
                $display("FAIL single_hold[%0d]: got %b want 10", i, {gnt_0, gnt_1});
            end
        end
        req_0 = 1'b0;
        step();
        tests_run++;
        if ({gnt_0, gnt_1} !== 2'b00) begin
            tests_failed++;
            $display("FAIL single_release: got %b want 00", {gnt_0, gnt_1});
        end
        req_1 = 1'b1;
        step();
        tests_run++;
        if ({gnt_0, gnt_1} !== 2'b01) begin
            tests_failed++;
            $display("FAIL single_req1: got %b want 01", {gnt_0, gnt_1});
        end
        req_1 = 1'b0;
        step();
        tests_run++;
        if ({gnt_0, gnt_1} !== 2'b00) begin
            tests_failed++;
            $display("FAIL single_req1_release: got %b want 00", {gnt_0, gnt_1});
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_second;
        do_reset();
        req_0 = 1'b1;
        req_1 = 1'b1;
        step();
        tests_run++;
        if ({gnt_0, gnt_1} !== 2'b10) begin
            tests_failed++;
            $display("FAIL contention_first: got %b want 10", {gnt_0, gnt_1});
        end
        req_0 = 1'b0;
        req_1 = 1'b0;
        step();
        tests_run++;
        if ({gnt_0, gnt_1} !== 2'b00) begin
            tests_failed++;
            $display("FAIL contention_release: got %b want 00", {gnt_0, gnt_1});
        end
        req_0 = 1'b1;
        req_1 = 1'b1;
        step();
`ifdef ARBITER_ROUND_ROBIN_EN
        exp_second = 2'b01;
`else
        exp_second = 2'b10;
`endif
        tests_run++;
        if ({gnt_0, gnt_1} !== exp_second) begin
            tests_failed++;
            $display("FAIL contention_second: got %b want %b", {gnt_0, gnt_1}, exp_second);
        end
        req_0 = 1'b0;
        req_1 = 1'b0;
        step();
    endtask

    task automatic test_hold();
        req_1 = 1'b1;
        step();
        tests_run++;
        if ({gnt_0, gnt_1} !== 2'b01) begin
            tests_failed++;
            $display("FAIL hold_grant1: got %b want 01", {gnt_0, gnt_1});
        end
        req_0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if ({gnt_0, gnt_1} !== 2'b01) begin
                tests_failed++;
                $display("FAIL hold_keep[%0d]: got %b want 01", i, {gnt_0, gnt_1});
            end
        end
        req_1 = 1'b0;
        step();
        tests_run++;
        if ({gnt_0, gnt_1} !== 2'b00) begin
            tests_failed++;
            $display("FAIL hold_gap: got %b want 00", {gnt_0, gnt_1});
        end
        step();
        tests_run++;
        if ({gnt_0, gnt_1} !== 2'b10) begin
            tests_failed++;
            $display("FAIL hold_handover: got %b want 10", {gnt_0, gnt_1});
        end
        req_0 = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_0 = 1'b1;
        req_1 = 1'b1;
        step();
        tests_run++;
        if ({gnt_0, gnt_1} !== 2'b10) begin
            tests_failed++;
            $display("FAIL b2b_grant0: got %b want 10", {gnt_0, gnt_1});
        end
        req_0 = 1'b0;
        step();
        tests_run++;
        if ({gnt_0, gnt_1} !== 2'b00) begin
            tests_failed++;
            $display("FAIL b2b_idle: got %b want 00", {gnt_0, gnt_1});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if ({gnt_0, gnt_1} !== 2'b01) begin
                tests_failed++;
                $display("FAIL b2b_grant1[%0d]: got %b want 01", i, {gnt_0, gnt_1});
            end
        end
        req_1 = 1'b0;
        step();
    endtask

    task automatic test_random();
        // Reference model: 0 idle, 1 owner 0, 2 owner 1.
        int         m_state;
        logic       m_last;
        logic [1:0] m_exp;
        do_reset();
        m_state = 0;
        m_last  = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            req_0 = 1'($urandom_range(0, 1));
            req_1 = 1'($urandom_range(0, 1));
            step();
            if (m_state == 1) begin
                m_state = req_0 ? 1 : 0;
            end else if (m_state == 2) begin
                m_state = req_1 ? 2 : 0;
            end else if (req_0 && req_1) begin
`ifdef ARBITER_ROUND_ROBIN_EN
                m_state = (m_last == 1'b1) ? 1 : 2;
`else
                m_state = 1;
`endif
            end else if (req_0) begin
                m_state = 1;
            end else if (req_1) begin
                m_state = 2;
            end
            if (m_state == 1) m_last = 1'b0;
            if (m_state == 2) m_last = 1'b1;
            m_exp = (m_state == 1) ? 2'b10 : ((m_state == 2) ? 2'b01 : 2'b00);
            tests_run++;
            if ((gnt_0 & gnt_1) !== 1'b0 || {gnt_0, gnt_1} !== m_exp) begin
                tests_failed++;
                $display("FAIL random[%0d]: got %b want %b", i, {gnt_0, gnt_1}, m_exp);
            end
        end
        req_0 = 1'b0;
        req_1 = 1'b0;
        step();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        req_0        = 1'b0;
        req_1        = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_hold();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
